// File: rtl/bg_scroll_gen_if.sv
// bg_scroll_gen_if: raster/control inputs and ROM-side outputs of the background scroll generator
//   h_cnt, v_cnt : raster position from the VGA timing counter
//   pause, dir   : scroll hold and direction controls
//   addr         : background ROM address
//   in_win       : window flag aligned to ROM data
//   ofs          : current scroll offset row
`timescale 1ns/1ps
interface bg_scroll_gen_if #(
    parameter int ADDR_W = 17,
    parameter int OFS_W  = 10
);
    logic [9:0]        h_cnt;
    logic [9:0]        v_cnt;
    logic              pause;
    logic              dir;
    logic [ADDR_W-1:0] addr;
    logic              in_win;
    logic [OFS_W-1:0]  ofs;

    modport master (output h_cnt, v_cnt, pause, dir, input addr, in_win, ofs);
    modport slave  (input h_cnt, v_cnt, pause, dir, output addr, in_win, ofs);
endinterface

// File: rtl/bg_scroll_gen.sv
// bg_scroll_gen: vertically scrolling background ROM address generator for the VGA pixel path
//   clk_25MHz : pixel clock, the only clock
//   rst       : asynchronous active-high reset
//   bus       : bg_scroll_gen_if.slave (h_cnt, v_cnt, pause, dir in; addr, in_win, ofs out)
//   BG_SCROLL_DIR_EN : when defined, dir selects step-up/step-down; otherwise only step-down is built
`timescale 1ns/1ps
module bg_scroll_gen #(
    parameter int WIN_X0      = 160,
    parameter int WIN_W       = 320,
    parameter int IMG_W       = 160,
    parameter int IMG_H       = 558,
    parameter int SCALE_SHIFT = 1,
    parameter int ADDR_W      = 17,
    parameter int OFS_W       = 10,
    parameter int TICK_DIV    = 4194304,
    parameter int ROM_LAT     = 1
) (
    input logic          clk_25MHz,
    input logic          rst,
    bg_scroll_gen_if.slave bus
);
    localparam int TW = $clog2(TICK_DIV);
    localparam int CW = $clog2(IMG_W);
    localparam int D  = ROM_LAT + 1;

    logic [TW-1:0]     tcnt_q, tcnt_d;
    logic              pend_q, pend_d;
    logic [OFS_W-1:0]  ofs_q, ofs_d, ofs_dn, ofs_nx;
    logic              tick, fstart, step, win;
    logic [CW-1:0]     col_q, col_d, col2_q;
    logic [OFS_W:0]    rsum_q, rsum_d;
    logic [OFS_W-1:0]  row_q, row_d;
    logic              w1_q, w2_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [D-1:0]      wd_q;

    always_comb begin
        tick   = tcnt_q == TW'(TICK_DIV - 1);
        tcnt_d = tick ? '0 : tcnt_q + 1'b1;
        fstart = (bus.h_cnt == '0) && (bus.v_cnt == '0);
        // Ticks collapse into one pending step; pause discards it outright.
        pend_d = (bus.pause || fstart) ? 1'b0 : (tick ? 1'b1 : pend_q);
        step   = fstart && (pend_q || tick) && !bus.pause;
        ofs_dn = (ofs_q == '0) ? OFS_W'(IMG_H - 1) : ofs_q - 1'b1;
        ofs_d  = step ? ofs_nx : ofs_q;
    end

`ifdef BG_SCROLL_DIR_EN
    logic [OFS_W-1:0] ofs_up;
    assign ofs_up = (ofs_q == OFS_W'(IMG_H - 1)) ? '0 : ofs_q + 1'b1;
    assign ofs_nx = bus.dir ? ofs_up : ofs_dn;
`else
    logic unused_dir;
    assign unused_dir = bus.dir;
    assign ofs_nx     = ofs_dn;
`endif

    always_comb begin
        win    = (bus.h_cnt >= 10'(WIN_X0)) && (bus.h_cnt < 10'(WIN_X0 + WIN_W));
        col_d  = CW'((bus.h_cnt - 10'(WIN_X0)) >> SCALE_SHIFT);
        // Stage 1 reads ofs_q, so the frame-start update only affects the next frame.
        rsum_d = (OFS_W + 1)'(bus.v_cnt >> SCALE_SHIFT) + {1'b0, ofs_q};
        // rsum < 2*IMG_H, so one conditional subtract replaces a modulo.
        row_d  = (rsum_q >= (OFS_W + 1)'(IMG_H)) ? OFS_W'(rsum_q - (OFS_W + 1)'(IMG_H))
                                                 : rsum_q[OFS_W-1:0];
        addr_d = w2_q ? ADDR_W'(row_q) * ADDR_W'(IMG_W) + ADDR_W'(col2_q) : '0;
    end

    always_ff @(posedge clk_25MHz or posedge rst) begin
        if (rst) begin
            tcnt_q <= '0;
            pend_q <= 1'b0;
            ofs_q  <= OFS_W'(IMG_H - 1);
            col_q  <= '0;
            rsum_q <= '0;
            w1_q   <= 1'b0;
            row_q  <= '0;
            col2_q <= '0;
            w2_q   <= 1'b0;
            addr_q <= '0;
            wd_q   <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            pend_q <= pend_d;
            ofs_q  <= ofs_d;
            col_q  <= col_d;
            rsum_q <= rsum_d;
            w1_q   <= win;
            row_q  <= row_d;
            col2_q <= col_q;
            w2_q   <= w1_q;
            addr_q <= addr_d;
            // One stage to match the address register, ROM_LAT more for the ROM itself.
            wd_q   <= D'({wd_q, w2_q});
        end
    end

    assign bus.addr   = addr_q;
    assign bus.in_win = wd_q[D-1];
    assign bus.ofs    = ofs_q;
endmodule

// File: tb/tb_bg_scroll_gen.sv
// tb_bg_scroll_gen: directed self-checking bench for bg_scroll_gen
`timescale 1ns/1ps
module tb_bg_scroll_gen;
    logic clk_25MHz = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int tc_m;
    int ofs_m;

    always #5 clk_25MHz = ~clk_25MHz;

    bg_scroll_gen_if #(.ADDR_W(17), .OFS_W(10)) bus ();

    bg_scroll_gen #(
        .WIN_X0(160), .WIN_W(320), .IMG_W(160), .IMG_H(558), .SCALE_SHIFT(1),
        .ADDR_W(17), .OFS_W(10), .TICK_DIV(4), .ROM_LAT(1)
    ) dut (
        .clk_25MHz(clk_25MHz),
        .rst(rst),
        .bus(bus)
    );

    // Phase of the 4-clock scroll divider, used only to align stimulus.
    always @(posedge clk_25MHz or posedge rst)
        if (rst) tc_m <= 0;
        else tc_m <= (tc_m + 1) % 4;

    typedef struct {
        int h;
        int v;
        int a;
        int w;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int step_m(input int o, input logic d);
`ifdef BG_SCROLL_DIR_EN
        if (d) return (o == 557) ? 0 : o + 1;
`endif
        return (o == 0) ? 557 : o - 1;
    endfunction

    task automatic drive(input int h, input int v);
        bus.h_cnt = 10'(h);
        bus.v_cnt = 10'(v);
    endtask

    // One frame-start cycle followed by n idle cycles; n >= 4 guarantees a tick before the next frame.
    task automatic frame(input int n);
        drive(0, 0);
        @(negedge clk_25MHz);
        if (!bus.pause) ofs_m = step_m(ofs_m, bus.dir);
        check("frame_step", int'(bus.ofs), ofs_m);
        drive(5, 0);
        repeat (n) begin
            @(negedge clk_25MHz);
            check("mid_frame_hold", int'(bus.ofs), ofs_m);
        end
    endtask

    initial begin
        vec_t tv[12];
        int prev;
        int hold;
        int exp_a;
        bit wrapped;
        tv[0]  = '{160, 0, 89120, 1};
        tv[1]  = '{479, 479, 38239, 1};
        tv[2]  = '{159, 10, 0, 0};
        tv[3]  = '{480, 10, 0, 0};
        tv[4]  = '{160, 2, 0, 1};
        tv[5]  = '{161, 1, 89120, 1};
        tv[6]  = '{162, 3, 1, 1};
        tv[7]  = '{300, 100, 7910, 1};
        tv[8]  = '{400, 524, 41880, 1};
        tv[9]  = '{799, 524, 0, 0};
        tv[10] = '{0, 5, 0, 0};
        tv[11] = '{478, 0, 89279, 1};

        bus.pause = 1'b0;
        bus.dir   = 1'b0;
        drive(10, 0);
        ofs_m = 557;
        repeat (2) @(negedge clk_25MHz);
        check("reset_addr", int'(bus.addr), 0);
        check("reset_in_win", int'(bus.in_win), 0);
        check("reset_ofs", int'(bus.ofs), 557);
        rst = 1'b0;
        @(negedge clk_25MHz);

        // Single in-window pixel to pin down addr and in_win latency.
        drive(160, 0);
        @(negedge clk_25MHz);
        drive(159, 0);
        check("lat_addr_c1", int'(bus.addr), 0);
        @(negedge clk_25MHz);
        check("lat_addr_c2", int'(bus.addr), 0);
        @(negedge clk_25MHz);
        check("lat_addr_c3", int'(bus.addr), 89120);
        check("lat_win_c3", int'(bus.in_win), 0);
        @(negedge clk_25MHz);
        check("lat_addr_c4", int'(bus.addr), 0);
        check("lat_win_c4", int'(bus.in_win), 1);
        @(negedge clk_25MHz);
        check("lat_win_c5", int'(bus.in_win), 0);

        for (int i = 0; i < 12; i++) begin
            drive(tv[i].h, tv[i].v);
            repeat (5) @(negedge clk_25MHz);
            check($sformatf("vec%0d_addr", i), int'(bus.addr), tv[i].a);
            check($sformatf("vec%0d_in_win", i), int'(bus.in_win), tv[i].w);
        end

        // Mid-frame reset while inside the window, then divider restart seen through frame-start steps.
        @(negedge clk_25MHz);
        #2 rst = 1'b1;
        #1;
        check("rstB_addr", int'(bus.addr), 0);
        check("rstB_in_win", int'(bus.in_win), 0);
        check("rstB_ofs", int'(bus.ofs), 557);
        @(negedge clk_25MHz);
        drive(0, 0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_25MHz);
            check("tcnt_restart_nostep", int'(bus.ofs), 557);
        end
        @(negedge clk_25MHz);
        ofs_m = 556;
        check("tcnt_restart_step", int'(bus.ofs), ofs_m);
        drive(5, 0);
        repeat (4) @(negedge clk_25MHz);

        // Scroll down through the 0 -> 557 wrap; 9 idle cycles carry two ticks that must collapse.
        wrapped = 1'b0;
        for (int f = 0; f < 700 && !wrapped; f++) begin
            prev = ofs_m;
            frame((f % 3 == 0) ? 9 : 4);
            if (prev == 0) wrapped = 1'b1;
        end
        check("wrap_seen", int'(wrapped), 1);
        check("wrap_value", int'(bus.ofs), 557);

        bus.dir = 1'b1;
        frame(4);
        frame(4);
        bus.dir = 1'b0;

        bus.pause = 1'b1;
        hold = ofs_m;
        repeat (3) frame(9);
        check("pause_hold", int'(bus.ofs), hold);

        // A pending step is dropped by pause; the next step needs a fresh tick.
        bus.pause = 1'b0;
        drive(5, 0);
        for (int k = 0; k < 8 && tc_m != 3; k++) @(negedge clk_25MHz);
        @(negedge clk_25MHz);
        bus.pause = 1'b1;
        @(negedge clk_25MHz);
        bus.pause = 1'b0;
        drive(0, 0);
        @(negedge clk_25MHz);
        check("pause_discard", int'(bus.ofs), ofs_m);
        drive(5, 0);
        @(negedge clk_25MHz);
        check("pause_wait_tick", int'(bus.ofs), ofs_m);
        drive(0, 0);
        @(negedge clk_25MHz);
        ofs_m = step_m(ofs_m, 1'b0);
        check("pause_release_step", int'(bus.ofs), ofs_m);
        drive(300, 100);

        repeat (5) @(negedge clk_25MHz);
        exp_a = ((50 + ofs_m) % 558) * 160 + 70;
        check("pre_rstA_addr", int'(bus.addr), exp_a);
        #2 rst = 1'b1;
        #1;
        check("rstA_addr", int'(bus.addr), 0);
        check("rstA_in_win", int'(bus.in_win), 0);
        check("rstA_ofs", int'(bus.ofs), 557);
        @(negedge clk_25MHz);
        rst = 1'b0;
        @(negedge clk_25MHz);
        check("resume_c1", int'(bus.addr), 0);
        @(negedge clk_25MHz);
        check("resume_c2", int'(bus.addr), 0);
        @(negedge clk_25MHz);
        check("resume_c3", int'(bus.addr), 7910);
        check("resume_win_c3", int'(bus.in_win), 0);
        @(negedge clk_25MHz);
        check("resume_win_c4", int'(bus.in_win), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/bg_scroll_gen.md
# bg_scroll_gen

Parametrised vertical-scrolling background address generator for the VGA pixel path. It maps the raster position (h_cnt, v_cnt) inside a configurable horizontal window to a linear address into a background image ROM. The image is scaled by 2^SCALE_SHIFT and scrolls with wrap-around at a rate set by an internal tick divider. All logic runs on the single pixel clock; scroll steps are frame-synchronous so no frame tears. It sits between the VGA timing counter and the background ROM, and `in_win` is aligned to the ROM output for the pixel mux.

## Interface
- WIN_X0, 160, first screen column of the background window
- WIN_W, 320, window width in screen pixels
- IMG_W, 160, image width in ROM words (must equal WIN_W>>SCALE_SHIFT)
- IMG_H, 558, image height in rows; scroll offset range is 0..IMG_H-1
- SCALE_SHIFT, 1, screen-to-image scale (screen coordinate >> SCALE_SHIFT); constraint: (524>>SCALE_SHIFT) < IMG_H
- ADDR_W, 17, ROM address width; IMG_W*IMG_H must be <= 2^ADDR_W
- OFS_W, 10, offset register width; IMG_H must be <= 2^OFS_W
- TICK_DIV, 4194304, pixel clocks per scroll tick (>= 2)
- ROM_LAT, 1, ROM read latency in clocks
- clk_25MHz  input  1  pixel clock; the only clock
- rst  input  1  asynchronous reset, active-high
- h_cnt  input  10  horizontal raster counter, 0..799
- v_cnt  input  10  vertical raster counter, 0..524
- pause  input  1  1 = hold the scroll offset
- dir  input  1  scroll direction: 0 = offset decrements, 1 = offset increments (used only with BG_SCROLL_DIR_EN)
- addr  output  ADDR_W  registered ROM address
- in_win  output  1  window flag, delayed to align with ROM data
- ofs  output  OFS_W  current scroll offset row

## Operation
- Tick divider: tcnt counts 0..TICK_DIV-1 and wraps. tick = (tcnt == TICK_DIV-1) for one cycle. The divider runs while paused.
- pending: set by tick, cleared at frame start or when pause=1.
- Frame start: the cycle where h_cnt==0 && v_cnt==0. If (pending | tick) && !pause, ofs steps by one.
- Multiple ticks within one frame collapse into one step.
- A tick on the frame-start cycle itself is applied in that same cycle.
- Step down: ofs==0 wraps to IMG_H-1, otherwise ofs-1. Step up: ofs==IMG_H-1 wraps to 0, otherwise ofs+1.
- Window: win = (h_cnt >= WIN_X0) && (h_cnt < WIN_X0+WIN_W).
- Stage 1 (registered):
  - col = (h_cnt-WIN_X0)>>SCALE_SHIFT
  - rsum = (v_cnt>>SCALE_SHIFT) + ofs, width OFS_W+1
  - w1 = win
- Stage 2 (registered):
  - row = rsum - IMG_H if rsum >= IMG_H, else rsum. A single subtract suffices because rsum < 2*IMG_H.
  - col2 = col; w2 = w1.
- Output: addr <= w2 ? row*IMG_W + col2 : 0. The product IMG_W is a constant multiply; no modulo operator.
- in_win is w2 delayed by ROM_LAT more clocks.
- Stage 1 samples ofs before the frame-start update. Pixel (0,0) lies outside the window, so every visible pixel of a frame uses one offset.

## Timing
- Reset values: addr=0, in_win=0, ofs=IMG_H-1, tcnt=0, pending=0, all pipeline registers 0.
- Reset mid-frame: outputs clear asynchronously. Normal addresses resume 3 clocks after rst deasserts.
- addr latency: 3 clocks from h_cnt/v_cnt, i.e. 2 pipeline stages plus the output register.
- in_win latency: 3+ROM_LAT clocks, coincident with douta for that pixel.
- ofs changes on the clock edge ending the frame-start cycle, at most once per frame.
- pause asserted: takes effect on the same cycle; any pending step is discarded.
- pause released: the next step needs a new tick.
- h_cnt outside the window gives addr=0 and in_win=0.

## Configuration
- BG_SCROLL_DIR_EN defined: the dir input selects step-up or step-down each frame, with both wrap rules active.
- BG_SCROLL_DIR_EN undefined: dir is ignored. Only step-down logic is built, so ofs decrements with wrap 0 -> IMG_H-1.

## Test plan
- Reset: assert rst mid-frame -> addr=0, in_win=0, ofs=557 immediately; tcnt restarts from 0 after release.
- Address at the top of the window: ofs=557, h=160, v=0 -> addr=89120 three clocks later, in_win=1 four clocks later.
- Row wrap: ofs=557, h=479, v=479 -> row=796-558=238, addr=38239.
- Window edges: h=159 and h=480 -> addr=0 and in_win=0; h=160 -> in_win=1.
- Frame-synchronous scroll (TICK_DIV=4): ofs changes only at h=v=0 and by exactly 1 per frame.
  - Default build: 0 -> 557.
  - BG_SCROLL_DIR_EN with dir=1: 557 -> 0.
- Pause: pause=1 across 3 frames -> ofs constant. Release, wait for the next tick -> one step at the following frame start.
